sad_best_match: RTL
===================

// Module: sad_best_match
// PURPOSE
//  Consumer side of the SAD datapath: accepts one 32-bit SAD result per candidate
//  block position and tracks the minimum and its (row,col) displacement.
//  Candidates are scanned raster order, NUM_ROWS x NUM_COLS per search.
//  Reports the best match to the motion-estimation controller with a done pulse.
// PARAMETERS
//  DATA_W      32  width of SAD value
//  NUM_ROWS    4   candidate rows per search (>=1)
//  NUM_COLS    4   candidate cols per search (>=1)
//  IDX_W       8   width of row/col index outputs (must hold NUM_ROWS-1, NUM_COLS-1)
//  EARLY_EXIT  1   1: accepting SAD==0 ends the search immediately
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous active-low reset
//  start       in   1       begin new search (sampled in IDLE only)
//  sad_valid   in   1       sad_in holds a valid SAD result
//  sad_in      in   DATA_W  SAD of current candidate (unsigned)
//  sad_ready   out  1       block accepts sad_in this cycle
//  busy        out  1       search in progress
//  done        out  1       one-cycle pulse: best_* final
//  best_sad    out  DATA_W  minimum SAD of last/current search
//  best_row    out  IDX_W   row of minimum
//  best_col    out  IDX_W   col of minimum
//  cand_count  out  16      candidates accepted in last/current search
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; sad_ready=0, busy=0, done=0,
//   best_sad=all ones, best_row=0, best_col=0, cand_count=0, row/col counters=0.
//  Transfer: accept = sad_valid & sad_ready; no transfer otherwise (sad_in ignored).
//  sad_ready is registered-state decoded: 1 only in SEARCH. sad_valid may rise/fall freely.
//  FSM: IDLE -> SEARCH on start; SEARCH -> DONE on accept of final candidate
//   (row=NUM_ROWS-1 & col=NUM_COLS-1) or, if EARLY_EXIT, on accept of sad_in==0;
//   DONE -> IDLE unconditionally after one cycle.
//  Entering SEARCH (edge after start): best_sad=all ones, best_row/col=0,
//   cand_count=0, row=col=0. busy=1 in SEARCH and DONE; done=1 only in DONE.
//  start while SEARCH or DONE: ignored. start in same cycle as DONE->IDLE: ignored;
//   needs a start in IDLE.
//  On accept: if sad_in < best_sad (strict, unsigned) update best_sad/row/col with
//   sad_in and current row/col; ties keep earlier candidate. cand_count+1 (saturates at
//   0xFFFF). col+1; col wraps NUM_COLS-1 -> 0 with row+1; after final candidate both
//   counters return to 0.
//  First accept always updates (best_sad starts all ones) unless sad_in==all ones;
//   then best stays (all ones,0,0) -- correct, position 0,0 holds it.
//  Latency: best_* reflect an accepted SAD the cycle after acceptance; done asserts
//   the cycle after the last accept, best_* already final in that cycle.
//  best_*/cand_count hold after DONE until next search start; they are undefined to
//   the consumer while busy=1 except in the done cycle.
//  NUM_ROWS=NUM_COLS=1: single accept -> DONE.
//  Reset mid-search: immediate return to reset values; partial results discarded.
// TESTING
//  T1 NUM_ROWS=NUM_COLS=2, start, SADs 40,12,30,25 back-to-back -> done 1 cyc after
//   4th accept; best_sad=12,row=0,col=1,cand_count=4.
//  T2 ties: SADs 7,9,7,7 -> best_sad=7,row=0,col=0 (earliest wins).
//  T3 EARLY_EXIT=1: SADs 50,0 -> done after 2nd accept, best_sad=0,row=0,col=1,
//   cand_count=2; EARLY_EXIT=0 same stream continues to 4 accepts.
//  T4 backpressure: sad_valid toggled 1,0,0,1,1,0,1 with random gaps, start pulsed during
//   SEARCH -> exactly 4 accepts counted, start ignored, result matches T1 stream order.
//  T5 default 4x4, SADs 100..85 descending -> best_sad=85,row=3,col=3,cand_count=16;
//   then new start clears best_sad to 0xFFFFFFFF the cycle after start.
//  T6 rst_n low after 2 accepts (async, mid-cycle) -> all outputs at reset values
//   immediately; sad_ready=0 until new start.

Source files
------------

// File: rtl/sad_best_match.sv
// Tracks the minimum SAD over one raster-scanned search window and reports
// its (row,col) displacement, with a one-cycle done pulse at the end.
module sad_best_match #(
    parameter int DATA_W     = 32,
    parameter int NUM_ROWS   = 4,
    parameter int NUM_COLS   = 4,
    parameter int IDX_W      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sad_valid,
    input  logic [DATA_W-1:0] sad_in,
    output logic              sad_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] best_sad,
    output logic [IDX_W-1:0]  best_row,
    output logic [IDX_W-1:0]  best_col,
    output logic [15:0]       cand_count
);

    // state  | meaning
    // IDLE   | waiting for start; results of last search held
    // SEARCH | accepting one SAD per candidate position
    // DONE   | one cycle, best_* final, done asserted
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(NUM_ROWS - 1);
    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(NUM_COLS - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] rowCnt;
    logic [IDX_W-1:0] colCnt;
    logic             accept;
    logic             lastCand;
    logic             zeroHit;
    logic             endSearch;

    assign sad_ready = (state == SEARCH);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    assign accept    = sad_valid & sad_ready;
    assign lastCand  = (rowCnt == LAST_ROW) && (colCnt == LAST_COL);
    assign zeroHit   = (EARLY_EXIT != 0) && (sad_in == '0);
    assign endSearch = lastCand || zeroHit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            best_sad   <= '1;
            best_row   <= '0;
            best_col   <= '0;
            cand_count <= '0;
            rowCnt     <= '0;
            colCnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SEARCH;
                        best_sad   <= '1;
                        best_row   <= '0;
                        best_col   <= '0;
                        cand_count <= '0;
                        rowCnt     <= '0;
                        colCnt     <= '0;
                    end
                end
                SEARCH: begin
                    if (accept) begin
                        // strict compare: a tie keeps the earlier position
                        if (sad_in < best_sad) begin
                            best_sad <= sad_in;
                            best_row <= rowCnt;
                            best_col <= colCnt;
                        end
                        if (cand_count != 16'hFFFF)
                            cand_count <= cand_count + 16'd1;
                        if (endSearch) begin
                            state  <= DONE;
                            rowCnt <= '0;
                            colCnt <= '0;
                        end else if (colCnt == LAST_COL) begin
                            colCnt <= '0;
                            rowCnt <= rowCnt + IDX_W'(1);
                        end else begin
                            colCnt <= colCnt + IDX_W'(1);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
